// File: rtl/alu_logic_bist.sv
// Built-in self-test engine for the ALU bitwise logic slice: walks every {b,a,op}
// vector, checks the slice result against a local golden model, and reports errors.
module alu_logic_bist #(
  parameter int WIDTH       = 3,
  parameter int NUM_VECTORS = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [1:0]           op,
  input  logic [WIDTH-1:0]     y,
  output logic [7:0]           err_count,
  output logic                 fail_vld,
  output logic [2*WIDTH+1:0]   fail_info,
  output logic [1:0]           state_dbg
);

  localparam int IW = 2 * WIDTH + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] golden;
  logic            mismatch;

  // The vector index itself is the registered stimulus: {b,a,op} = idx.
  assign op        = idx[1:0];
  assign a         = idx[WIDTH+1:2];
  assign b         = idx[IW-1:WIDTH+2];
  assign state_dbg = state;

  always_comb begin
    golden = '0;
    case (op)
      2'b00:   golden = a & b;
      2'b01:   golden = a | b;
      2'b10:   golden = a ^ b;
      default: golden = ~(a ^ b);
    endcase
  end

  // In simulation an X/Z on y must register as a failure, hence the 4-state compare.
`ifdef SYNTHESIS
  assign mismatch = (y != golden);
`else
  assign mismatch = (y !== golden);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRIVE;
      S_DRIVE: state_nxt = S_CHECK;
      S_CHECK: state_nxt = (idx == LAST_IDX) ? S_DONE : S_DRIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vld  <= 1'b0;
      fail_info <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vld  <= 1'b0;
            fail_info <= '0;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (!fail_vld) begin
              fail_vld  <= 1'b1;
              fail_info <= idx;
            end
          end
          if (idx == LAST_IDX) busy <= 1'b0;
          else                 idx  <= idx + 1'b1;
        end
        S_DONE: begin
          done <= 1'b1;
          pass <= (err_count == 8'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
